// File: rtl/litedram_axi_pkg.sv
// Shared AXI encodings, FSM state type and address constants for the LiteDRAM AXI tester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package litedram_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_SIZE_8B    = 4'd3;

    // 64-bit beats: byte address advances by 8 per beat.
    localparam int BEAT_SHIFT = 3;
    localparam int ADDR_W     = 27;
    localparam int DATA_W     = 64;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WR_AW,
        WR_W,
        WR_B,
        RD_AR,
        RD_R,
        DONE
    } state_e;

endpackage

// File: rtl/litedram_axi_pattern.sv
// Address-derived test pattern: {~zero-extended addr, zero-extended addr}.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of addr_i.
//   addr_i : 27-bit beat byte address
//   data_o : 64-bit expected beat data
module litedram_axi_pattern
    import litedram_axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    logic [31:0] addr_ext;

    assign addr_ext = {5'b0, addr_i};
    assign data_o   = {~addr_ext, addr_ext};

endmodule

// File: rtl/litedram_axi_tester.sv
// AXI4 traffic tester: writes an address pattern over a DDR region in INCR bursts, reads back and compares.
// Latency: valids assert the cycle after entering the owning state; one transaction outstanding at a time.
// Backpressure: AW/W/AR hold valid and payload until ready; B/R accepted unconditionally in their states.
//   user_clk/user_rst       : clock, async active-high reset
//   i_start/i_init_done     : pass start (level, IDLE/DONE only), calibration done
//   o_busy/o_done/o_pass    : status; o_pass meaningful while o_done
//   o_err_count/o_first_err_addr : saturating error count, address of first failing beat
//   o_aw*/o_w*/o_b*/o_ar*/o_r*   : AXI4 master, 64-bit data
module litedram_axi_tester
    import litedram_axi_pkg::*;
#(
    parameter int                ID_WIDTH   = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 27'h0000000,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 1024
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  i_start,
    input  logic                  i_init_done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [15:0]           o_err_count,
    output logic [ADDR_W-1:0]     o_first_err_addr,

    output logic [ID_WIDTH-1:0]   o_awid,
    output logic [ADDR_W-1:0]     o_awaddr,
    output logic [7:0]            o_awlen,
    output logic [3:0]            o_awsize,
    output logic [1:0]            o_awburst,
    output logic                  o_awvalid,
    input  logic                  i_awready,

    output logic [DATA_W-1:0]     o_wdata,
    output logic [7:0]            o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,

    input  logic [ID_WIDTH-1:0]   i_bid,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,

    output logic [ID_WIDTH-1:0]   o_arid,
    output logic [ADDR_W-1:0]     o_araddr,
    output logic [7:0]            o_arlen,
    output logic [3:0]            o_arsize,
    output logic [1:0]            o_arburst,
    output logic                  o_arvalid,
    input  logic                  i_arready,

    input  logic [ID_WIDTH-1:0]   i_rid,
    input  logic [DATA_W-1:0]     i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    state_e               state_q, state_d;
    logic [15:0]          burst_idx_q, burst_idx_d;
    // One bit wider than needed for 0..BURST_LEN-1 so the read side can park at
    // BURST_LEN while draining a burst that overran without rlast.
    logic [8:0]           beat_q, beat_d;
    logic [15:0]          err_q, err_d;
    logic [ADDR_W-1:0]    first_q, first_d;

    logic [ADDR_W-1:0]    burst_addr;
    logic [ADDR_W-1:0]    beat_addr;
    logic [DATA_W-1:0]    pat_data;
    logic                 last_beat;
    logic                 last_burst;
    logic                 in_burst;
    logic                 err_hit;
    logic [ADDR_W-1:0]    err_addr;

    // IDs on responses are deliberately ignored.
    logic                 unused_ids;
    assign unused_ids = ^{i_bid, i_rid};

    assign burst_addr = BASE_ADDR
                      + ((ADDR_W'(burst_idx_q) * ADDR_W'(BURST_LEN)) << BEAT_SHIFT);
    assign beat_addr  = burst_addr + (ADDR_W'(beat_q) << BEAT_SHIFT);
    assign last_beat  = (beat_q == 9'(BURST_LEN - 1));
    assign in_burst   = (beat_q < 9'(BURST_LEN));
    assign last_burst = (burst_idx_q == 16'(NUM_BURSTS - 1));

    // Only one of write-data generation and read compare is active at a time,
    // so a single pattern instance serves both.
    litedram_axi_pattern u_pattern (
        .addr_i (beat_addr),
        .data_o (pat_data)
    );

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q     <= IDLE;
            burst_idx_q <= '0;
            beat_q      <= '0;
            err_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_idx_q <= burst_idx_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_idx_d = burst_idx_q;
        beat_d      = beat_q;
        err_d       = err_q;
        first_d     = first_q;
        err_hit     = 1'b0;
        err_addr    = '0;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    err_d       = '0;
                    first_d     = '0;
                    burst_idx_d = '0;
                    beat_d      = '0;
                    state_d     = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (i_init_done) begin
                    state_d = WR_AW;
                end
            end
            WR_AW: begin
                if (i_awready) begin
                    beat_d  = '0;
                    state_d = WR_W;
                end
            end
            WR_W: begin
                if (i_wready) begin
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        state_d = WR_B;
                    end
                end
            end
            WR_B: begin
                if (i_bvalid) begin
                    if (i_bresp != AXI_RESP_OKAY) begin
                        err_hit  = 1'b1;
                        err_addr = burst_addr;
                    end
                    if (last_burst) begin
                        burst_idx_d = '0;
                        state_d     = RD_AR;
                    end else begin
                        burst_idx_d = burst_idx_q + 16'd1;
                        state_d     = WR_AW;
                    end
                end
            end
            RD_AR: begin
                if (i_arready) begin
                    beat_d  = '0;
                    state_d = RD_R;
                end
            end
            RD_R: begin
                if (i_rvalid) begin
                    // Beats past the expected end are drained unchecked; the
                    // overrun was already logged on the last expected beat.
                    if (in_burst && ((i_rdata != pat_data) ||
                                     (i_rresp != AXI_RESP_OKAY) ||
                                     (i_rlast != last_beat))) begin
                        err_hit  = 1'b1;
                        err_addr = beat_addr;
                    end
                    if (i_rlast) begin
                        if (last_burst) begin
                            state_d = DONE;
                        end else begin
                            burst_idx_d = burst_idx_q + 16'd1;
                            state_d     = RD_AR;
                        end
                    end else if (in_burst) begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_hit) begin
            if (err_q == 16'd0) begin
                first_d = err_addr;
            end
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    // Valids decode straight from the state register, so the async reset
    // drops them immediately.
    assign o_awvalid = (state_q == WR_AW);
    assign o_wvalid  = (state_q == WR_W);
    assign o_bready  = (state_q == WR_B);
    assign o_arvalid = (state_q == RD_AR);
    assign o_rready  = (state_q == RD_R);

    assign o_busy           = (state_q != IDLE) && (state_q != DONE);
    assign o_done           = (state_q == DONE);
    assign o_pass           = o_done && (err_q == 16'd0);
    assign o_err_count      = err_q;
    assign o_first_err_addr = first_q;

    assign o_awid    = '0;
    assign o_awaddr  = o_awvalid ? burst_addr : '0;
    assign o_awlen   = 8'(BURST_LEN - 1);
    assign o_awsize  = AXI_SIZE_8B;
    assign o_awburst = AXI_BURST_INCR;

    assign o_wdata = o_wvalid ? pat_data : '0;
    assign o_wstrb = 8'hFF;
    assign o_wlast = o_wvalid && last_beat;

    assign o_arid    = '0;
    assign o_araddr  = o_arvalid ? burst_addr : '0;
    assign o_arlen   = 8'(BURST_LEN - 1);
    assign o_arsize  = AXI_SIZE_8B;
    assign o_arburst = AXI_BURST_INCR;

endmodule
